rps_match_ctrl: RTL and testbench
=================================

Name: rps_match_ctrl

Overview:
Match controller on the requesting side of the RPS judge interface. It collects one move per player from the input front-end and drives the judge's move/start inputs. It waits for the judge's ready, captures the result and keeps a first-to-WIN_TARGET score. It sits between the button/debounce logic and the judge, and feeds the display logic.

Parameters:
WIN_TARGET, 3, wins needed to end a match (1..2^SCORE_W-1)
SCORE_W, 3, width of score and tie counters
TIMEOUT, 15, max cycles in WAIT before error (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
new_match  in  1  one-cycle pulse: clear scores, start new match
p1_valid  in  1  player-1 move strobe
p1_move  in  2  player-1 move: 00 rock, 01 paper, 10 scissors, 11 invalid
p2_valid  in  1  player-2 move strobe
p2_move  in  2  player-2 move, same encoding
judge_move1  out  2  move presented to judge for player 1
judge_move2  out  2  move presented to judge for player 2
judge_start  out  1  judge start, registered, one-cycle pulse
judge_result  in  2  judge result: 00 none, 01 P1 win, 10 P2 win, 11 tie
judge_ready  in  1  judge result valid (result != 00)
p1_locked  out  1  player-1 move held for current round
p2_locked  out  1  player-2 move held for current round
p1_score  out  SCORE_W  player-1 wins this match
p2_score  out  SCORE_W  player-2 wins this match
ties  out  SCORE_W  ties this match, saturating
last_result  out  2  most recent captured judge result
round_done  out  1  one-cycle pulse when a round is scored
match_over  out  1  high in DONE
winner  out  2  01 P1, 10 P2, 00 while match running
error  out  1  high in ERR, judge did not answer

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State COLLECT.
  - All outputs 0, including judge_move1/2=00 and judge_start=0.
  - Latches, counters and wait counter cleared.
- Priority: rst_n, then new_match, then state logic. new_match in any state does the reset actions except that judge_* outputs keep their values, with judge_start forced 0.
- Move capture:
  - A move is latched only in COLLECT.
  - A move is latched when px_valid=1, px_move!=11 and that player is not yet locked.
  - The latch sets px_locked on the next cycle.
  - Invalid moves and strobes after lock are ignored.
  - Both players may strobe in the same cycle, and both are latched.
- State machine:
  - COLLECT: when p1_locked & p2_locked, load judge_move1/2 from the latches and go to START.
  - START: judge_start=1 for exactly this one cycle, then go to WAIT with wait counter 0.
  - WAIT: judge_move1/2 held stable. The first WAIT cycle is blanking, and judge_ready is ignored because the judge is clearing. From the second cycle, if judge_ready=1 and judge_result!=00, capture it into last_result and go to SCORE. Otherwise increment the counter. When counter==TIMEOUT, go to ERR.
  - SCORE (1 cycle): round_done=1.
    - 01: p1_score+1.
    - 10: p2_score+1.
    - 11: ties+1, saturating at all-ones.
    - If a score reaches WIN_TARGET, go to DONE with winner set. Otherwise clear locks and go to COLLECT.
  - DONE: match_over=1, winner held. Strobes ignored. Leave only on new_match or reset.
  - ERR: error=1, scores held. Leave only on new_match or reset, which go to COLLECT.
- Latency:
  - Second lock to judge_start: 1 cycle.
  - judge_start to earliest capture: 2 cycles.
  - Capture to score update: 1 cycle.
- Scores never wrap: WIN_TARGET terminates the match before overflow.
- judge_start is never asserted outside START.

Test Plan:
- Reset, then P1 rock and P2 scissors strobed in the same cycle; judge returns 01 two cycles after start → p1_score=1, round_done one pulse, locks clear, back to COLLECT.
- P1 paper at t0, P1 rock at t3 (ignored), P2 paper at t5; judge 11 → judge_move1=01, ties=1, scores 0/0.
- P1 strobes move 11 → p1_locked stays 0; a later valid 10 locks with judge_move1=10.
- Three rounds with judge 10 each (WIN_TARGET=3) → p2_score=3, match_over=1, winner=10; further strobes have no effect; new_match → all counters 0, COLLECT.
- Judge never raises ready → error=1 after TIMEOUT WAIT cycles, judge_start pulsed once only; new_match clears error.
- rst_n=0 asserted during WAIT → next cycle all outputs 0 and state COLLECT; a late judge_ready is ignored.

Source files
------------

// File: rtl/rps_match_ctrl.sv
// rps_match_ctrl
//   Requesting-side match controller for the rock/paper/scissors judge.
//   Collects one move per player, hands the pair to the judge, waits for a
//   result and keeps a first-to-WIN_TARGET score with a saturating tie count.
//   If the judge never answers, the controller parks in an error state.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   new_match                  pulse: clear scores/locks and start a new match
//   p1_valid/p1_move           player-1 move strobe and move (11 = invalid)
//   p2_valid/p2_move           player-2 move strobe and move (11 = invalid)
//   judge_move1/judge_move2    moves presented to the judge
//   judge_start                one-cycle start pulse to the judge
//   judge_result/judge_ready   judge answer (01 P1, 10 P2, 11 tie) and its valid
//   p1_locked/p2_locked        player move held for the current round
//   p1_score/p2_score/ties     match counters
//   last_result                most recent captured judge result
//   round_done                 one-cycle pulse while a round is being scored
//   match_over/winner          match finished and who won (01 P1, 10 P2)
//   error                      judge did not answer in time
module rps_match_ctrl #(
  parameter int WIN_TARGET = 3,
  parameter int SCORE_W    = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               new_match,
  input  logic               p1_valid,
  input  logic [1:0]         p1_move,
  input  logic               p2_valid,
  input  logic [1:0]         p2_move,
  output logic [1:0]         judge_move1,
  output logic [1:0]         judge_move2,
  output logic               judge_start,
  input  logic [1:0]         judge_result,
  input  logic               judge_ready,
  output logic               p1_locked,
  output logic               p2_locked,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [SCORE_W-1:0] ties,
  output logic [1:0]         last_result,
  output logic               round_done,
  output logic               match_over,
  output logic [1:0]         winner,
  output logic               error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [SCORE_W-1:0] WIN_T = SCORE_W'(WIN_TARGET);
  localparam logic [CNT_W-1:0]   TMO   = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_START,
    S_WAIT,
    S_SCORE,
    S_DONE,
    S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         p1_mv_q, p1_mv_d;
  logic [1:0]         p2_mv_q, p2_mv_d;
  logic               p1_lock_q, p1_lock_d;
  logic               p2_lock_q, p2_lock_d;
  logic [1:0]         jm1_q, jm1_d;
  logic [1:0]         jm2_q, jm2_d;
  logic               js_q, js_d;
  logic [SCORE_W-1:0] p1_sc_q, p1_sc_d;
  logic [SCORE_W-1:0] p2_sc_q, p2_sc_d;
  logic [SCORE_W-1:0] tie_q, tie_d;
  logic [1:0]         last_q, last_d;
  logic [1:0]         win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Player scores cannot wrap: the match ends as soon as one reaches WIN_T.
  logic [SCORE_W-1:0] p1_inc, p2_inc;
  assign p1_inc = p1_sc_q + SCORE_W'(1);
  assign p2_inc = p2_sc_q + SCORE_W'(1);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    p1_mv_d   = p1_mv_q;
    p2_mv_d   = p2_mv_q;
    p1_lock_d = p1_lock_q;
    p2_lock_d = p2_lock_q;
    jm1_d     = jm1_q;
    jm2_d     = jm2_q;
    js_d      = 1'b0;
    p1_sc_d   = p1_sc_q;
    p2_sc_d   = p2_sc_q;
    tie_d     = tie_q;
    last_d    = last_q;
    win_d     = win_q;
    cnt_d     = cnt_q;

    if (new_match) begin
      // Same as reset, except the judge move lines keep their last values.
      state_d   = S_COLLECT;
      p1_mv_d   = 2'b00;
      p2_mv_d   = 2'b00;
      p1_lock_d = 1'b0;
      p2_lock_d = 1'b0;
      p1_sc_d   = '0;
      p2_sc_d   = '0;
      tie_d     = '0;
      last_d    = 2'b00;
      win_d     = 2'b00;
      cnt_d     = '0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (p1_valid && (p1_move != 2'b11) && !p1_lock_q) begin
            p1_mv_d   = p1_move;
            p1_lock_d = 1'b1;
          end
          if (p2_valid && (p2_move != 2'b11) && !p2_lock_q) begin
            p2_mv_d   = p2_move;
            p2_lock_d = 1'b1;
          end
          if (p1_lock_q && p2_lock_q) begin
            jm1_d   = p1_mv_q;
            jm2_d   = p2_mv_q;
            js_d    = 1'b1;
            state_d = S_START;
          end
        end
        S_START: begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // Count 0 is the blanking cycle while the judge clears its result.
          if ((cnt_q != '0) && judge_ready && (judge_result != 2'b00)) begin
            last_d  = judge_result;
            state_d = S_SCORE;
          end else if (cnt_q == TMO) begin
            state_d = S_ERR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_SCORE: begin
          p1_lock_d = 1'b0;
          p2_lock_d = 1'b0;
          state_d   = S_COLLECT;
          case (last_q)
            2'b01: begin
              p1_sc_d = p1_inc;
              if (p1_inc == WIN_T) begin
                win_d     = 2'b01;
                p1_lock_d = p1_lock_q;
                p2_lock_d = p2_lock_q;
                state_d   = S_DONE;
              end
            end
            2'b10: begin
              p2_sc_d = p2_inc;
              if (p2_inc == WIN_T) begin
                win_d     = 2'b10;
                p1_lock_d = p1_lock_q;
                p2_lock_d = p2_lock_q;
                state_d   = S_DONE;
              end
            end
            2'b11:   tie_d = sat_inc(tie_q);
            default: ;
          endcase
        end
        S_DONE:  state_d = S_DONE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_COLLECT;
      p1_mv_q   <= 2'b00;
      p2_mv_q   <= 2'b00;
      p1_lock_q <= 1'b0;
      p2_lock_q <= 1'b0;
      jm1_q     <= 2'b00;
      jm2_q     <= 2'b00;
      js_q      <= 1'b0;
      p1_sc_q   <= '0;
      p2_sc_q   <= '0;
      tie_q     <= '0;
      last_q    <= 2'b00;
      win_q     <= 2'b00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      p1_mv_q   <= p1_mv_d;
      p2_mv_q   <= p2_mv_d;
      p1_lock_q <= p1_lock_d;
      p2_lock_q <= p2_lock_d;
      jm1_q     <= jm1_d;
      jm2_q     <= jm2_d;
      js_q      <= js_d;
      p1_sc_q   <= p1_sc_d;
      p2_sc_q   <= p2_sc_d;
      tie_q     <= tie_d;
      last_q    <= last_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
    end
  end

  assign judge_move1 = jm1_q;
  assign judge_move2 = jm2_q;
  assign judge_start = js_q;
  assign p1_locked   = p1_lock_q;
  assign p2_locked   = p2_lock_q;
  assign p1_score    = p1_sc_q;
  assign p2_score    = p2_sc_q;
  assign ties        = tie_q;
  assign last_result = last_q;
  assign round_done  = (state_q == S_SCORE);
  assign match_over  = (state_q == S_DONE);
  assign winner      = win_q;
  assign error       = (state_q == S_ERR);

endmodule

// File: tb/tb_rps_match_ctrl.sv
module tb_rps_match_ctrl;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_match = 1'b0;
  logic       p1_valid = 1'b0;
  logic [1:0] p1_move = 2'b00;
  logic       p2_valid = 1'b0;
  logic [1:0] p2_move = 2'b00;
  logic [1:0] judge_result = 2'b00;
  logic       judge_ready = 1'b0;
  logic [1:0] judge_move1, judge_move2, last_result, winner;
  logic       judge_start, p1_locked, p2_locked, round_done, match_over, error;
  logic [2:0] p1_score, p2_score, ties;

  rps_match_ctrl #(.WIN_TARGET(3), .SCORE_W(3), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .new_match(new_match),
    .p1_valid(p1_valid), .p1_move(p1_move),
    .p2_valid(p2_valid), .p2_move(p2_move),
    .judge_move1(judge_move1), .judge_move2(judge_move2),
    .judge_start(judge_start), .judge_result(judge_result),
    .judge_ready(judge_ready), .p1_locked(p1_locked), .p2_locked(p2_locked),
    .p1_score(p1_score), .p2_score(p2_score), .ties(ties),
    .last_result(last_result), .round_done(round_done),
    .match_over(match_over), .winner(winner), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] last;
    logic [2:0] p1, p2, tie;
    logic       over;
    logic [1:0] win;
  } rexp_t;

  logic [3:0] start_q[$];
  rexp_t      round_q[$];
  int         checks = 0;
  int         failures = 0;
  int         start_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations when the DUT presents a start or a scored round.
  initial begin
    rexp_t cur;
    bit    pend = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 0;
        chk("p1_score", p1_score, cur.p1);
        chk("p2_score", p2_score, cur.p2);
        chk("ties", ties, cur.tie);
        chk("match_over", match_over, cur.over);
        chk("winner", winner, cur.win);
        chk("round_done_pulse", round_done, 0);
      end
      if (round_done) begin
        if (round_q.size() == 0) begin
          chk("unexpected_round_done", 1, 0);
        end else begin
          cur = round_q.pop_front();
          chk("last_result", last_result, cur.last);
          pend = 1;
        end
      end
      if (judge_start) begin
        start_cnt++;
        if (start_q.size() == 0) begin
          chk("unexpected_judge_start", 1, 0);
        end else begin
          chk("judge_moves", {judge_move1, judge_move2}, start_q.pop_front());
        end
      end
    end
  end

  task automatic strobe(input logic v1, input logic [1:0] m1,
                        input logic v2, input logic [1:0] m2);
    p1_valid = v1; p1_move = m1; p2_valid = v2; p2_move = m2;
    @(negedge clk);
    p1_valid = 0; p2_valid = 0; p1_move = 0; p2_move = 0;
  endtask

  task automatic pulse_new_match();
    new_match = 1;
    @(negedge clk);
    new_match = 0;
  endtask

  task automatic wait_start(output bit ok);
    int n = 0;
    while (!judge_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = judge_start;
    if (!ok) chk("judge_start_timeout", 0, 1);
  endtask

  // Judge model: optional garbage during the blanking cycle, then the answer.
  task automatic judge_answer(input logic [1:0] res, input bit noisy);
    bit ok;
    wait_start(ok);
    if (!ok) return;
    @(negedge clk);
    judge_ready  = noisy;
    judge_result = noisy ? ((res == 2'b01) ? 2'b10 : 2'b01) : 2'b00;
    @(negedge clk);
    judge_ready = 1; judge_result = res;
    @(negedge clk);
    judge_ready = 0; judge_result = 0;
    repeat (2) @(negedge clk);
  endtask

  function automatic rexp_t mk(input logic [1:0] l, input int a, input int b,
                               input int t, input logic o, input logic [1:0] w);
    rexp_t r;
    r.last = l; r.p1 = 3'(a); r.p2 = 3'(b); r.tie = 3'(t); r.over = o; r.win = w;
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_jm"}, {judge_move1, judge_move2}, 0);
    chk({tag, "_js"}, judge_start, 0);
    chk({tag, "_locks"}, {p1_locked, p2_locked}, 0);
    chk({tag, "_scores"}, {p1_score, p2_score, ties}, 0);
    chk({tag, "_last"}, last_result, 0);
    chk({tag, "_flags"}, {round_done, match_over, error, winner}, 0);
  endtask

  initial begin
    int sc;
    int n;
    bit ok;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1;
    @(negedge clk);

    // Round 1: rock vs scissors in one cycle, P1 wins.
    start_q.push_back({2'b00, 2'b10});
    round_q.push_back(mk(2'b01, 1, 0, 0, 0, 2'b00));
    strobe(1, 2'b00, 1, 2'b10);
    chk("t1_locks", {p1_locked, p2_locked}, 2'b11);
    judge_answer(2'b01, 0);
    chk("t1_locks_clear", {p1_locked, p2_locked}, 2'b00);

    // Round 2: second P1 strobe ignored after lock, tie; noisy blanking cycle.
    start_q.push_back({2'b01, 2'b01});
    round_q.push_back(mk(2'b11, 1, 0, 1, 0, 2'b00));
    strobe(1, 2'b01, 0, 2'b00);
    chk("t2_lock_a", {p1_locked, p2_locked}, 2'b10);
    @(negedge clk);
    strobe(1, 2'b00, 0, 2'b00);
    chk("t2_lock_b", {p1_locked, p2_locked}, 2'b10);
    @(negedge clk);
    strobe(0, 2'b00, 1, 2'b01);
    judge_answer(2'b11, 1);

    // Round 3: invalid move ignored, then scissors locks.
    strobe(1, 2'b11, 0, 2'b00);
    chk("t3_invalid_nolock", p1_locked, 0);
    start_q.push_back({2'b10, 2'b00});
    round_q.push_back(mk(2'b10, 1, 1, 1, 0, 2'b00));
    strobe(1, 2'b10, 0, 2'b00);
    chk("t3_valid_lock", p1_locked, 1);
    strobe(0, 2'b00, 1, 2'b00);
    judge_answer(2'b10, 0);

    // New match, then P2 wins three straight.
    pulse_new_match();
    chk("nm_scores", {p1_score, p2_score, ties}, 0);
    chk("nm_last_win", {last_result, winner, match_over}, 0);
    chk("nm_jm_kept", {judge_move1, judge_move2}, {2'b10, 2'b00});
    for (int r = 1; r <= 3; r++) begin
      start_q.push_back({2'b00, 2'b01});
      round_q.push_back(mk(2'b10, 0, r, 0, (r == 3), (r == 3) ? 2'b10 : 2'b00));
      strobe(1, 2'b00, 1, 2'b01);
      judge_answer(2'b10, 0);
    end
    sc = start_cnt;
    strobe(1, 2'b01, 1, 2'b10);
    repeat (4) @(negedge clk);
    chk("done_no_start", start_cnt, sc);
    chk("done_held", {match_over, winner, p2_score}, {1'b1, 2'b10, 3'd3});
    chk("done_jm", {judge_move1, judge_move2}, {2'b00, 2'b01});
    pulse_new_match();
    chk("nm2_clear", {p1_score, p2_score, ties, match_over, winner, p1_locked, p2_locked}, 0);

    // Judge never answers: timeout into ERR.
    sc = start_cnt;
    start_q.push_back({2'b00, 2'b01});
    strobe(1, 2'b00, 1, 2'b01);
    wait_start(ok);
    n = 0;
    while (!error && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, TIMEOUT + 2);
    repeat (3) @(negedge clk);
    chk("err_held", {error, match_over, p1_score, p2_score}, {1'b1, 1'b0, 6'd0});
    chk("err_one_start", start_cnt - sc, 1);
    pulse_new_match();
    chk("err_cleared", {error, p1_locked, p2_locked}, 0);

    // A tie, then reset during WAIT with a late judge answer.
    start_q.push_back({2'b00, 2'b00});
    round_q.push_back(mk(2'b11, 0, 0, 1, 0, 2'b00));
    strobe(1, 2'b00, 1, 2'b00);
    judge_answer(2'b11, 0);
    sc = start_cnt;
    start_q.push_back({2'b01, 2'b10});
    strobe(1, 2'b01, 1, 2'b10);
    wait_start(ok);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk_all_zero("wait_rst");
    judge_ready = 1; judge_result = 2'b01;
    repeat (4) @(negedge clk);
    judge_ready = 0; judge_result = 0;
    @(negedge clk);
    chk("late_ready_ignored", {p1_score, last_result, round_done}, 0);
    chk("late_ready_no_start", start_cnt - sc, 1);

    repeat (2) @(negedge clk);
    chk("start_q_empty", start_q.size(), 0);
    chk("round_q_empty", round_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
